// File: rtl/uart_rx_axi.sv
// uart_rx_axi: 8-bit UART receiver feeding a receive FIFO, exposed through an
// AXI4-Lite slave (DATA at 0x0, STATUS at 0x4).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit (8E1 framing).
module uart_rx_axi #(
  parameter int unsigned CLK_DIV    = 234,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        irq
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic { R_IDLE, R_RESP } r_state_t;
  typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;

  logic            rx_meta, rx_sync, rx_prev, rx_fall;
  rx_state_t       rx_state, rx_state_d;
  logic [15:0]     baud_cnt, baud_cnt_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            push_req, ferr_set, perr_set, ovr_set, push_ok, pop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty;
  logic            ovr, ferr, perr;
  logic [31:0]     status_word;

  r_state_t        r_state, r_state_d;
  w_state_t        w_state, w_state_d;
  logic            ar_hs, aw_hs, w_hs;
  logic [1:0]      wsel;
  logic [2:0]      clr;

  logic            unused;
  assign unused = ^{awaddr[31:4], awaddr[1:0], araddr[31:4], araddr[1:0],
                    wdata[31:5], wdata[1:0], wstrb[3:1]};

  // Two-flop synchroniser plus previous-value flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      rx_state <= rx_state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
    end
  end

  // Receiver next-state: mid-bit sampling, LSB-first shift, framing checks
  always_comb begin
    rx_state_d = rx_state;
    baud_cnt_d = baud_cnt + 16'd1;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
    perr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        baud_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt == HALF_M1) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_cnt == FULL_M1) begin
          baud_cnt_d = '0;
          shreg_d    = {rx_sync, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      // A bad parity bit ends the frame here; the stop bit that follows is
      // high, so IDLE will not mistake it for a new start edge.
      RX_PARITY: begin
        if (baud_cnt == FULL_M1) begin
          baud_cnt_d = '0;
          if (rx_sync != ^shreg) begin
            perr_set   = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (baud_cnt == FULL_M1) begin
          baud_cnt_d = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync) push_req = 1'b1;
          else         ferr_set = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign irq     = ~empty;
  assign pop     = ar_hs & (araddr[3:2] == 2'd0) & ~empty;
  assign push_ok = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  // FIFO storage (no reset needed: occupancy gates every read)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags: a set event in the same cycle beats a W1C clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~clr[0]);
      ferr <= ferr_set | (ferr & ~clr[1]);
      perr <= perr_set | (perr & ~clr[2]);
    end
  end

  assign status_word = {16'h0000, 8'(count), 3'b000, perr, ferr, ovr, full, ~empty};

  // Read channel state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_d;
  end

  // Read channel next-state and handshake outputs
  always_comb begin
    r_state_d = r_state;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_d = R_RESP;
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign ar_hs = arvalid & arready;

  // Read data and response captured on the AR handshake, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_hs) begin
      case (araddr[3:2])
        2'd0: begin
          rdata <= empty ? 32'h0 : {1'b1, 23'h0, mem[rd_ptr]};
          rresp <= 2'b00;
        end
        2'd1: begin
          rdata <= status_word;
          rresp <= 2'b00;
        end
        default: begin
          rdata <= '0;
          rresp <= 2'b10;
        end
      endcase
    end
  end

  // Write channel state, latched register select and response code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wsel    <= '0;
      bresp   <= 2'b00;
    end else begin
      w_state <= w_state_d;
      if (aw_hs) wsel  <= awaddr[3:2];
      if (w_hs)  bresp <= (wsel == 2'd1) ? 2'b00 : 2'b10;
    end
  end

  // Write channel next-state and handshake outputs
  always_comb begin
    w_state_d = w_state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_d = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) w_state_d = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign clr   = (w_hs && wsel == 2'd1 && wstrb[0]) ? wdata[4:2] : 3'b000;

endmodule

// File: tb/tb_uart_rx_axi.sv
// tb_uart_rx_axi: self-checking bench for uart_rx_axi at CLK_DIV=16,
// FIFO_DEPTH=8, using a queue-based reference model of the receive path.
module tb_uart_rx_axi;

  localparam int BIT_CYC = 16;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        irq;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] m_q[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

  uart_rx_axi #(.CLK_DIV(BIT_CYC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_status();
    int sz = m_q.size();
    return (32'(sz) << 8) | {27'h0, m_perr, m_ferr, m_ovr, sz == DEPTH, sz != 0};
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic line_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  // Sends one frame and updates the model with what the receiver should do.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(par);
`endif
    line_bit(stop);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    if (par != even_par(d)) begin
      m_perr = 1'b1;
      return;
    end
`endif
    if (!stop) m_ferr = 1'b1;
    else if (m_q.size() == DEPTH) m_ovr = 1'b1;
    else m_q.push_back(d);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, even_par(d));
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100) begin n_fail++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1; n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100) begin n_fail++; $display("FAIL r_timeout: rvalid=%b required 1", rvalid); end
    d = rdata; r = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = d; wstrb = s; n = 0;
    while (!wready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    wvalid = 1'b0; bready = 1'b1; n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100) begin n_fail++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
    r = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid, irq} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 110000",
               {arready, awready, wready, rvalid, bvalid, irq});
    end
    n_cmp++;
    if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b required 0", rdata, rresp, bresp);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] d; logic [1:0] r;
    send_byte(8'h55);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b required 1", irq); end
    axi_read(32'h0, d, r);
    n_cmp++;
    if (d !== 32'h80000055 || r !== 2'b00) begin
      n_fail++; $display("FAIL single_read: got %h/%b required 80000055/00", d, r);
    end
    void'(m_q.pop_front());
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_fall: got %b required 0", irq); end
  endtask

  task automatic test_empty_read();
    logic [31:0] d; logic [1:0] r;
    axi_read(32'h0, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b00) begin
      n_fail++; $display("FAIL empty_read: got %h/%b required 00000000/00", d, r);
    end
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== model_status()) begin
      n_fail++; $display("FAIL empty_status: got %h required %h", d, model_status());
    end
  endtask

  task automatic test_random();
    logic [31:0] d; logic [1:0] r; logic [7:0] e;
    int nb = $urandom_range(3, 6);
    for (int i = 0; i < nb; i++) send_byte(8'($urandom));
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== model_status()) begin
      n_fail++; $display("FAIL rand_status: got %h required %h", d, model_status());
    end
    while (m_q.size() != 0) begin
      e = m_q.pop_front();
      axi_read(32'h0, d, r);
      n_cmp++;
      if (d !== {1'b1, 23'h0, e} || r !== 2'b00) begin
        n_fail++; $display("FAIL rand_data: got %h/%b required %h/00", d, r, {1'b1, 23'h0, e});
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [1:0] r; logic [7:0] e;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom));
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== 32'h00000807 || d !== model_status()) begin
      n_fail++; $display("FAIL ovr_status: got %h required 00000807", d);
    end
    axi_write(32'h4, 32'h4, 4'h1, r);
    m_ovr = 1'b0;
    n_cmp++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL ovr_w1c_resp: got %b required 00", r); end
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== 32'h00000803) begin
      n_fail++; $display("FAIL ovr_cleared: got %h required 00000803", d);
    end
    while (m_q.size() != 0) begin
      e = m_q.pop_front();
      axi_read(32'h0, d, r);
      n_cmp++;
      if (d !== {1'b1, 23'h0, e}) begin
        n_fail++; $display("FAIL ovr_drain: got %h required %h", d, {1'b1, 23'h0, e});
      end
    end
  endtask

  task automatic test_ferr_glitch();
    logic [31:0] d; logic [1:0] r;
    send_frame(8'($urandom), 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
    m_perr = 1'b0;
`endif
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d[3] !== 1'b1 || d[15:8] !== 8'h00 || d !== model_status()) begin
      n_fail++; $display("FAIL ferr_status: got %h required %h", d, model_status());
    end
    axi_write(32'h4, 32'h1C, 4'h1, r);
    m_ferr = 1'b0; m_perr = 1'b0;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * BIT_CYC) @(negedge clk);
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL glitch_status: got %h irq=%b required 00000000 irq=0", d, irq);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h0, 32'hFF, 4'hF, r);
    n_cmp++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL wr_data_resp: got %b required 10", r); end
    axi_read(32'h8, d, r);
    n_cmp++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++; $display("FAIL rd_unmapped: got %h/%b required 00000000/10", d, r);
    end
    axi_write(32'hC, 32'h1C, 4'hF, r);
    n_cmp++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL wr_unmapped_resp: got %b required 10", r); end
  endtask

  task automatic test_hold();
    logic [31:0] snap; logic [7:0] e; int n = 0;
    e = 8'($urandom);
    send_byte(e);
    void'(m_q.pop_front());
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h0;
    @(negedge clk);
    arvalid = 1'b0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    snap = rdata;
    n_cmp++;
    if (snap !== {1'b1, 23'h0, e}) begin
      n_fail++; $display("FAIL hold_data: got %h required %h", snap, {1'b1, 23'h0, e});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== snap) begin
        n_fail++; $display("FAIL hold_stable: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, snap);
      end
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL hold_release: rvalid=%b required 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(a[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(even_par(a));
`endif
    line_bit(1'b1);
    m_q.push_back(a);
    send_byte(b);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] e = m_q.pop_front();
      axi_read(32'h0, d, r);
      n_cmp++;
      if (d !== {1'b1, 23'h0, e}) begin
        n_fail++; $display("FAIL b2b_data: got %h required %h", d, {1'b1, 23'h0, e});
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic [1:0] r;
    send_byte(8'hA5);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0 || arready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs: irq=%b arready=%b required 0/1", irq, arready);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (12 * BIT_CYC) @(negedge clk);
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== model_status()) begin
      n_fail++; $display("FAIL midreset_status: got %h required %h", d, model_status());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] d; logic [1:0] r;
    send_frame(8'h01, 1'b1, 1'b0);
    axi_read(32'h4, d, r);
    n_cmp++;
    if (d !== 32'h00000010) begin
      n_fail++; $display("FAIL parity_bad: got %h required 00000010", d);
    end
    send_frame(8'h01, 1'b1, 1'b1);
    axi_read(32'h0, d, r);
    void'(m_q.pop_front());
    n_cmp++;
    if (d !== 32'h80000001) begin
      n_fail++; $display("FAIL parity_good: got %h required 80000001", d);
    end
    axi_write(32'h4, 32'h10, 4'h1, r);
    m_perr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_empty_read();
    test_random();
    test_overflow();
    test_ferr_glitch();
    test_errors();
    test_hold();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_axi.md
UART_RX_AXI -- requirements
Module: uart_rx_axi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 234, meaning clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; a power of two in the range 2..64.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port uart_rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have ports awvalid/awready (in/out, 1) and awaddr (in, 32), the AXI4-Lite write address channel.
REQ-007 SHALL have ports wvalid/wready (in/out, 1), wdata (in, 32) and wstrb (in, 4), the AXI4-Lite write data channel.
REQ-008 SHALL have ports bvalid/bready (out/in, 1) and bresp (out, 2), the AXI4-Lite write response channel.
REQ-009 SHALL have ports arvalid/arready (in/out, 1) and araddr (in, 32), the AXI4-Lite read address channel.
REQ-010 SHALL have ports rvalid/rready (out/in, 1), rdata (out, 32) and rresp (out, 2), the AXI4-Lite read data channel.
REQ-011 SHALL have port irq  output  1  high while the FIFO is non-empty.

Function
REQ-012 SHALL synchronise uart_rx through two flops before use; the synchronised line resets to 1.
REQ-013 SHALL implement receiver states IDLE, START, DATA, STOP (and PARITY when REQ-030 applies), with an internal bit counter and baud counter.
REQ-014 IDLE->START on a synchronised falling edge; START samples at CLK_DIV/2 cycles: low -> DATA, high -> IDLE as a glitch, with no push and no error.
REQ-015 DATA SHALL sample 8 bits LSB-first, one every CLK_DIV cycles, then go to STOP (or PARITY).
REQ-016 STOP samples after CLK_DIV cycles: high -> push the byte, low -> discard the byte and set sticky FERR; both return to IDLE.
REQ-017 SHALL push into a full FIFO only if a pop occurs in the same cycle; otherwise it drops the byte and sets sticky OVR.
REQ-018 Register map by araddr/awaddr[3:2]: 0 = DATA (RO), 1 = STATUS; codes 2 and 3 are unmapped.
REQ-019 DATA read: rdata[7:0] = FIFO head, rdata[31] = 1, and the head is popped; if the FIFO is empty, rdata = 0 and no pop occurs.
REQ-020 STATUS read: bit0 = not empty, bit1 = full, bit2 = OVR, bit3 = FERR, bit4 = PERR, bits[15:8] = occupancy, all other bits 0.
REQ-021 A STATUS write with wstrb[0]=1 SHALL clear each of bits[4:2] whose wdata bit is 1 (W1C); a set event in the same cycle wins over the clear.
REQ-022 Read FSM is R_IDLE (arready=1) then R_RESP (rvalid=1, held until rready). rdata and the pop are captured on the AR handshake; rvalid follows one cycle later.
REQ-023 Write FSM is W_IDLE (awready=1), then W_DATA (wready=1), then W_RESP (bvalid=1 until bready); the register update occurs on the W handshake.
REQ-024 rresp/bresp SHALL be 2'b00 OKAY for mapped addresses and 2'b10 SLVERR for unmapped addresses or a write to DATA; errored writes change no state and errored reads return 0.
REQ-025 The read and write FSMs are independent and may be active concurrently.

Reset
REQ-026 rst_n low SHALL asynchronously clear both FSMs to their idle states, empty the FIFO, clear OVR/FERR/PERR, and return the receiver to IDLE.
REQ-027 Output reset values: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, irq=0.
REQ-028 A reset asserted mid-frame or mid-transaction SHALL abandon it; the partial byte is never pushed.
REQ-029 After reset release, the receiver SHALL only accept a new falling edge.

Configuration
REQ-030 With UART_RX_PARITY_EN defined, an even-parity bit follows the data; on mismatch the byte is discarded and sticky PERR is set.
REQ-031 Without UART_RX_PARITY_EN: no PARITY state exists (8N1 framing), and STATUS bit4 reads 0.

Verification
REQ-032 Send byte 0x55 at CLK_DIV=16, then read addr 0x0 -> rdata=0x80000055, rresp=0, irq falls.
REQ-033 Read addr 0x0 with the FIFO empty -> rdata=0x00000000, rresp=0, no state change.
REQ-034 Send 9 bytes with FIFO_DEPTH=8 and no reads -> STATUS=0x00000807; the ninth byte is lost; writing 0x4 to STATUS -> STATUS=0x00000803.
REQ-035 Send a frame with stop bit 0 -> STATUS bit3=1 and occupancy 0; a 3-cycle low glitch on idle -> no change.
REQ-036 Write to addr 0x0 and read addr 0x8 -> bresp=2'b10 and rresp=2'b10; hold rready=0 for 5 cycles -> rvalid and rdata stay stable.
REQ-037 With UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 -> discarded and PERR=1; with parity bit 1 -> accepted.
